muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit in the execute stage. Takes the two operands read from the register bank (`rd1`/`rd2` values) plus the destination index, computes iteratively one bit per cycle, and presents result, destination index and write enable in the form of the register bank write port (`wd3`/`a3`/`we3`). Fixed latency for all eight M-extension operations. Handshake is start/busy/done.

---
 rtl/muldiv_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit
// ---------------------------------------------------------------------------
// Iterative RV32M multiply/divide unit for the execute stage. One operand bit
// is processed per clock, so every operation takes the same 33 cycles from
// acceptance to the done pulse. The outputs have the same shape as the
// register bank write port, so they can drive it directly.
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst_n   in   1  synchronous active-low reset
//   start   in   1  request, only honoured while idle
//   funct3  in   3  M-extension operation select
//   op_a    in  32  rs1 value
//   op_b    in  32  rs2 value
//   rd_in   in   5  destination register index
//   busy    out  1  unit is working; the issuing stage must stall
//   done    out  1  one-cycle pulse, result/rd_out valid
//   result  out 32  write-back data (wd3)
//   rd_out  out  5  write-back index (a3)
//   we      out  1  write enable (we3), suppressed for x0
// ---------------------------------------------------------------------------
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic        signa_q, signa_d;
  logic        signb_q, signb_d;
  logic [31:0] amag_q, amag_d;
  logic [31:0] bmag_q, bmag_d;
  logic [63:0] acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rdout_q, rdout_d;

  // Operand signedness of the incoming request.
  logic        inASigned, inBSigned;
  logic        inANeg, inBNeg;
  logic [31:0] inAMag, inBMag;

  assign inASigned = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign inBSigned = inASigned && (funct3 != 3'b010);
  assign inANeg    = inASigned & op_a[31];
  assign inBNeg    = inBSigned & op_b[31];
  assign inAMag    = inANeg ? (~op_a + 32'd1) : op_a;
  assign inBMag    = inBNeg ? (~op_b + 32'd1) : op_b;

  // Multiply step: acc holds {partial product high, remaining multiplier}.
  // The multiplicand is added into the upper half when the current
  // multiplier bit is set, then the whole register shifts right by one.
  logic [32:0] mulSum;
  logic [63:0] mulNext;

  assign mulSum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, amag_q} : 33'd0);
  assign mulNext = {mulSum, acc_q[31:1]};

  // Restoring divide step: acc holds {partial remainder, dividend/quotient}.
  // The next dividend bit shifts into the remainder; if the divisor fits it
  // is subtracted and a 1 shifts into the quotient end.
  logic [32:0] divTrial, divDiff;
  logic        divFits;
  logic [63:0] divNext;

  assign divTrial = {acc_q[63:32], acc_q[31]};
  assign divDiff  = divTrial - {1'b0, bmag_q};
  assign divFits  = (divTrial >= {1'b0, bmag_q});
  assign divNext  = {(divFits ? divDiff[31:0] : divTrial[31:0]), acc_q[30:0], divFits};

  // Sign correction and result selection, consumed in FIX.
  logic [63:0] prodFix;
  logic [31:0] quotFix, remFix;
  logic        divByZero, divOverflow;
  logic [31:0] fixResult;

  assign prodFix     = (signa_q ^ signb_q) ? (~acc_q + 64'd1) : acc_q;
  assign quotFix     = (signa_q ^ signb_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign remFix      = signa_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  assign divByZero   = (opb_q == 32'd0);
  assign divOverflow = (opa_q == 32'h8000_0000) && (opb_q == 32'hFFFF_FFFF);

  // Divide-by-zero and signed overflow bypass the iterated result; the
  // iteration still runs so the latency stays fixed.
  always_comb begin
    fixResult = 32'd0;
    case (f3_q)
      3'b000:  fixResult = prodFix[31:0];
      3'b001,
      3'b010,
      3'b011:  fixResult = prodFix[63:32];
      3'b100:  fixResult = divByZero ? 32'hFFFF_FFFF :
                           divOverflow ? 32'h8000_0000 : quotFix;
      3'b101:  fixResult = divByZero ? 32'hFFFF_FFFF : quotFix;
      3'b110:  fixResult = divByZero ? opa_q :
                           divOverflow ? 32'd0 : remFix;
      default: fixResult = divByZero ? opa_q : remFix;
    endcase
  end

  // Next-state and datapath logic. Everything holds by default; each state
  // only overrides what it changes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rd_d     = rd_q;
    signa_d  = signa_q;
    signb_d  = signb_q;
    amag_d   = amag_q;
    bmag_d   = bmag_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    result_d = result_q;
    rdout_d  = rdout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d    = funct3;
          opa_d   = op_a;
          opb_d   = op_b;
          rd_d    = rd_in;
          signa_d = inANeg;
          signb_d = inBNeg;
          amag_d  = inAMag;
          bmag_d  = inBMag;
          acc_d   = funct3[2] ? {32'd0, inAMag} : {32'd0, inBMag};
          cnt_d   = 6'd0;
          state_d = CALC;
        end
      end

      CALC: begin
        acc_d = f3_q[2] ? divNext : mulNext;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIX;
        end
      end

      FIX: begin
        result_d = fixResult;
        rdout_d  = rd_q;
        done_d   = 1'b1;
        we_d     = (rd_q != 5'd0);
        state_d  = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset wins over any request on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      f3_q     <= 3'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      rd_q     <= 5'd0;
      signa_q  <= 1'b0;
      signb_q  <= 1'b0;
      amag_q   <= 32'd0;
      bmag_q   <= 32'd0;
      acc_q    <= 64'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= 32'd0;
      rdout_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      signa_q  <= signa_d;
      signb_q  <= signb_d;
      amag_q   <= amag_d;
      bmag_q   <= bmag_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      result_q <= result_d;
      rdout_q  <= rdout_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we     = we_q;
  assign result = result_q;
  assign rd_out = rdout_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// ---------------------------------------------------------------------------
// Scoreboard bench for muldiv_unit. Directed vectors push their hand-computed
// expectation into a queue when issued; an independent monitor pops and
// compares whenever the unit pulses done, including the 33-cycle latency.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          acceptCyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   doneCount = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we     (we)
  );

  // Free-running clock and an edge counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: counts it, reports a FAIL line when it does not hold.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      doneCount++;
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("rd_out", 32'(rd_out), 32'(e.rd));
        checkOutput("we", 32'(we), 32'(e.we));
        checkOutput("latency", 32'(cyc - e.acceptCyc), 32'd33);
      end
    end
    if (we === 1'b1 && done !== 1'b1) begin
      checkOutput("we_without_done", 32'(we), 32'd0);
    end
  end

  // Waits, with a cycle budget, for every queued expectation to be consumed.
  task automatic waitDrain();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      checkOutput("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  // Issues one request on a falling edge and queues its expected response.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expRes);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    e.res = expRes;
    e.rd  = rd;
    e.we  = (rd != 5'd0);
    e.acceptCyc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    waitDrain();
  endtask

  initial begin
    int e0;
    int d0;
    exp_t e;

    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'd0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    rd_in  = 5'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_rd_out", 32'(rd_out), 32'd0);
    rst_n = 1'b1;

    // Multiply, unsigned and signed high halves.
    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 32'hFFFF_FFFE);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 32'h0000_0001);
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000);
    applyStimulus(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd9, 32'h2345_6780);

    // Signed and unsigned divide.
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD);
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF);
    applyStimulus(3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'h7FFF_FFFC);
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd12, 32'h0000_0003);
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFF);
    applyStimulus(3'b111, 32'd100, 32'd7, 5'd13, 32'd2);

    // Divide by zero and signed overflow.
    applyStimulus(3'b101, 32'h0000_1234, 32'h0000_0000, 5'd14, 32'hFFFF_FFFF);
    applyStimulus(3'b111, 32'h0000_1234, 32'h0000_0000, 5'd14, 32'h0000_1234);
    applyStimulus(3'b100, 32'hFFFF_1234, 32'h0000_0000, 5'd15, 32'hFFFF_FFFF);
    applyStimulus(3'b110, 32'hFFFF_1234, 32'h0000_0000, 5'd15, 32'hFFFF_1234);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000);

    // Writes to x0 complete but do not enable the write port.
    applyStimulus(3'b000, 32'd2, 32'd3, 5'd0, 32'd6);

    // Requests while busy are dropped: pulses at acceptance+5 and +33.
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd5;
    rd_in  = 5'd7;
    e.res = 32'd15;
    e.rd  = 5'd7;
    e.we  = 1'b1;
    e.acceptCyc = cyc + 1;
    e0 = cyc + 1;
    sbq.push_back(e);
    d0 = doneCount;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 4) @(negedge clk);
    start = 1'b1;
    op_a  = 32'd100;
    op_b  = 32'd100;
    rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 32) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 45) @(negedge clk);
    #1;
    checkOutput("busy_drop_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("busy_drop_queue_empty", 32'(sbq.size()), 32'd0);
    checkOutput("busy_drop_idle", 32'(busy), 32'd0);
    sbq.delete();

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    rd_in  = 5'd3;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_rd_out", 32'(rd_out), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    d0 = doneCount;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", 32'(doneCount - d0), 32'd0);
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd3, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
